spi_slave: RTL and testbench

- Memory-mapped SPI device-side (slave) peripheral. It is the far end of the SoC's SPI master link.
- Attaches to a bus slave port using the same data_i/addr_i/we_i/data_o convention as the other peripherals. Lets an external SPI master exchange bytes with the CPU.
- Fixed to SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames. Single-byte TX and RX buffers. RX interrupt output.

---
 rtl/spi_slave.sv | 176 +++++++++++++++++
 tb/tb_spi_slave.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// Memory-mapped SPI mode-0 slave: 8-bit MSB-first frames, single-byte TX/RX buffers,
// level RX interrupt. SCK, SS_N and MOSI are synchronised into the clk domain.
module spi_slave #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  DUMMY_BYTE  = 8'hFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_i,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   output logic [31:0] data_o,
   input  logic        spi_clk,
   input  logic        spi_ss,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   output logic        int_sig_o
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sck_d;
   logic                   ss_d;
   logic                   sck_s;
   logic                   ss_s;
   logic                   mosi_s;
   logic                   sck_rise;
   logic                   sck_fall;
   logic                   ss_fall;
   logic                   ss_rise;

   logic [0:0] state;
   logic [3:0] bit_cnt;
   logic [7:0] tx_sh;
   logic [7:0] rx_sh;
   logic [7:0] rx_next;
   logic [7:0] tx_buf;
   logic [7:0] rx_buf;
   logic [7:0] load_val;
   logic       en;
   logic       rx_ie;
   logic       rx_valid;
   logic       rx_ovr;
   logic       tx_empty;
   logic       busy;
   logic       tx_load;
   logic       wr_ctrl;
   logic       wr_status;
   logic       wr_tx;
   logic       unused_bits;

   assign unused_bits = ^{addr_i[31:4], data_i[31:8]};

   // Synchroniser and edge history are deliberately not reset: a reset in the middle of
   // a frame must not fabricate an ss_n edge from the still-low pin.
   always_ff @(posedge clk) begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_d     <= sck_s;
      ss_d      <= ss_s;
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign ss_s     = ss_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign ss_fall  = ~ss_s & ss_d;
   assign ss_rise  = ss_s & ~ss_d;

   assign wr_ctrl   = we_i && (addr_i[3:0] == 4'h0);
   assign wr_status = we_i && (addr_i[3:0] == 4'h4);
   assign wr_tx     = we_i && (addr_i[3:0] == 4'h8);

   assign busy     = (state == ST_SHIFT);
   assign load_val = tx_empty ? DUMMY_BYTE : tx_buf;
   assign rx_next  = {rx_sh[6:0], mosi_s};

   // A byte starts either on frame entry or on the first SCK fall after a complete byte.
   always_comb begin
      tx_load = 1'b0;
      if (state == ST_IDLE) begin
         tx_load = ss_fall && en;
      end else if (!ss_rise && !sck_rise && sck_fall && (bit_cnt == 4'd8)) begin
         tx_load = 1'b1;
      end
   end

   // Statement order resolves same-cycle conflicts: W1C before byte completion,
   // TX-buffer consumption before a new TXDATA write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         tx_sh       <= '0;
         rx_sh       <= '0;
         tx_buf      <= '0;
         rx_buf      <= '0;
         en          <= 1'b0;
         rx_ie       <= 1'b0;
         rx_valid    <= 1'b0;
         rx_ovr      <= 1'b0;
         tx_empty    <= 1'b1;
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
         int_sig_o   <= 1'b0;
      end else begin
         int_sig_o <= rx_ie & rx_valid;

         if (wr_ctrl) begin
            en    <= data_i[0];
            rx_ie <= data_i[1];
         end
         if (wr_status) begin
            if (data_i[0]) rx_valid <= 1'b0;
            if (data_i[2]) rx_ovr   <= 1'b0;
         end

         if (tx_load) begin
            tx_sh    <= load_val;
            spi_miso <= load_val[7];
            bit_cnt  <= '0;
            tx_empty <= 1'b1;
         end
         if (wr_tx) begin
            tx_buf   <= data_i[7:0];
            tx_empty <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (ss_fall && en) begin
                  state       <= ST_SHIFT;
                  spi_miso_oe <= 1'b1;
               end
            end
            default: begin
               if (ss_rise) begin
                  state       <= ST_IDLE;
                  spi_miso_oe <= 1'b0;
                  spi_miso    <= 1'b0;
                  bit_cnt     <= '0;
               end else if (sck_rise) begin
                  rx_sh   <= rx_next;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     rx_buf   <= rx_next;
                     rx_valid <= 1'b1;
                     if (rx_valid) rx_ovr <= 1'b1;
                  end
               end else if (sck_fall && (bit_cnt >= 4'd1) && (bit_cnt <= 4'd7)) begin
                  tx_sh    <= {tx_sh[6:0], 1'b0};
                  spi_miso <= tx_sh[6];
               end
            end
         endcase
      end
   end

   always_comb begin
      data_o = '0;
      case (addr_i[3:0])
         4'h0:    data_o = {30'd0, rx_ie, en};
         4'h4:    data_o = {28'd0, busy, rx_ovr, tx_empty, rx_valid};
         4'hC:    data_o = {24'd0, rx_buf};
         default: data_o = '0;
      endcase
   end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: register table, directed SPI frames, and randomized
// frames checked against a byte-level model of the buffers and status flags.
module tb_spi_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] data_i = '0;
   logic [31:0] addr_i = '0;
   logic        we_i = 1'b0;
   logic [31:0] data_o;
   logic        spi_clk = 1'b0;
   logic        spi_ss = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic        spi_miso_oe;
   logic        int_sig_o;

   int checks = 0;
   int errors = 0;

   logic [7:0] mo_b [4];
   logic [7:0] mi_b [4];
   logic       oe_seen;

   typedef struct {
      logic        we;
      logic [3:0]  waddr;
      logic [31:0] wdata;
      logic [3:0]  raddr;
      logic [31:0] exp;
   } reg_vec_t;

   spi_slave #(.SYNC_STAGES(2), .DUMMY_BYTE(8'hFF)) dut (
      .clk(clk), .rst(rst), .data_i(data_i), .addr_i(addr_i), .we_i(we_i), .data_o(data_o),
      .spi_clk(spi_clk), .spi_ss(spi_ss), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .spi_miso_oe(spi_miso_oe), .int_sig_o(int_sig_o)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      addr_i = {28'd0, a};
      data_i = d;
      we_i   = 1'b1;
      @(negedge clk);
      we_i   = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      addr_i = {28'd0, a};
      we_i   = 1'b0;
      #1 d = data_o;
   endtask

   task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(a, d);
      check(name, d, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clks(2);
      rst = 1'b0;
   endtask

   // Master side, sck = clk/8; MISO is sampled just before each rising edge.
   task automatic send_bytes(input int n);
      for (int b = 0; b < n; b++) begin
         for (int i = 7; i >= 0; i--) begin
            spi_mosi = mo_b[b][i];
            clks(4);
            mi_b[b][i] = spi_miso;
            oe_seen = oe_seen | spi_miso_oe;
            spi_clk = 1'b1;
            clks(4);
            spi_clk = 1'b0;
         end
      end
   endtask

   task automatic frame(input int n);
      oe_seen = 1'b0;
      spi_ss = 1'b0;
      clks(8);
      send_bytes(n);
      clks(6);
      spi_ss = 1'b1;
      clks(6);
   endtask

   reg_vec_t vecs [10];
   logic [31:0] rd;

   // Byte-level reference model.
   logic [7:0] m_tx_buf, m_rx_buf;
   logic       m_tx_empty, m_rx_valid, m_rx_ovr;
   logic [7:0] exp_mi [4];

   initial begin
      vecs[0] = '{1'b0, 4'h0, 32'h0,        4'h4, 32'h2};
      vecs[1] = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h0};
      vecs[2] = '{1'b0, 4'h0, 32'h0,        4'hC, 32'h0};
      vecs[3] = '{1'b1, 4'h0, 32'hFFFFFFFF, 4'h0, 32'h3};
      vecs[4] = '{1'b1, 4'h0, 32'h0,        4'h0, 32'h0};
      vecs[5] = '{1'b1, 4'h0, 32'h3,        4'h0, 32'h3};
      vecs[6] = '{1'b1, 4'h1, 32'hFC,       4'h0, 32'h3};
      vecs[7] = '{1'b1, 4'h4, 32'hFFFFFFFF, 4'h4, 32'h2};
      vecs[8] = '{1'b1, 4'h8, 32'h12345677, 4'h4, 32'h0};
      vecs[9] = '{1'b1, 4'h8, 32'h000000A5, 4'h3, 32'h0};

      clks(3);
      rst = 1'b0;
      clks(1);
      check("reset_miso_oe", {31'd0, spi_miso_oe}, 32'h0);
      check("reset_miso", {31'd0, spi_miso}, 32'h0);
      check("reset_int", {31'd0, int_sig_o}, 32'h0);

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].we) bus_write(vecs[i].waddr, vecs[i].wdata);
         read_check($sformatf("reg_vec%0d", i), vecs[i].raddr, vecs[i].exp);
      end

      // Basic transfer with a loaded TX buffer.
      mo_b[0] = 8'h3C;
      frame(1);
      check("t2_miso_byte", {24'd0, mi_b[0]}, 32'hA5);
      read_check("t2_rxdata", 4'hC, 32'h3C);
      read_check("t2_status", 4'h4, 32'h3);
      check("t2_int", {31'd0, int_sig_o}, 32'h1);
      check("t2_oe_after", {31'd0, spi_miso_oe}, 32'h0);
      bus_write(4'h4, 32'h5);

      // Empty TX buffer shifts out the dummy byte.
      mo_b[0] = 8'h81;
      frame(1);
      check("t3_dummy", {24'd0, mi_b[0]}, 32'hFF);
      read_check("t3_rxdata", 4'hC, 32'h81);
      bus_write(4'h4, 32'h5);

      // Back-to-back bytes under one select cause an overrun.
      mo_b[0] = 8'h11;
      mo_b[1] = 8'h22;
      frame(2);
      read_check("t4_rxdata", 4'hC, 32'h22);
      read_check("t4_status", 4'h4, 32'h7);
      bus_write(4'h4, 32'h5);
      read_check("t4_status_clr", 4'h4, 32'h2);
      clks(1);
      check("t4_int_clr", {31'd0, int_sig_o}, 32'h0);

      // Partial frame: five SCK edges then deselect.
      spi_ss = 1'b0;
      clks(8);
      spi_mosi = 1'b1;
      for (int e = 0; e < 5; e++) begin
         clks(4);
         spi_clk = ~spi_clk;
      end
      clks(4);
      read_check("t5_busy", 4'h4, 32'hA);
      check("t5_oe_mid", {31'd0, spi_miso_oe}, 32'h1);
      spi_clk = 1'b0;
      clks(4);
      spi_ss = 1'b1;
      clks(6);
      read_check("t5_status", 4'h4, 32'h2);
      check("t5_oe", {31'd0, spi_miso_oe}, 32'h0);
      mo_b[0] = 8'h7E;
      frame(1);
      read_check("t5_rxdata", 4'hC, 32'h7E);
      bus_write(4'h4, 32'h5);

      // Reset in the middle of a frame.
      spi_ss = 1'b0;
      clks(8);
      for (int e = 0; e < 3; e++) begin
         clks(4);
         spi_clk = ~spi_clk;
      end
      rst = 1'b1;
      clks(1);
      rst = 1'b0;
      read_check("t6_status", 4'h4, 32'h2);
      read_check("t6_ctrl", 4'h0, 32'h0);
      read_check("t6_rxdata", 4'hC, 32'h0);
      check("t6_oe", {31'd0, spi_miso_oe}, 32'h0);
      clks(4);
      spi_clk = 1'b0;
      clks(4);
      spi_ss = 1'b1;
      clks(6);
      mo_b[0] = 8'h99;
      frame(1);
      check("t6_oe_disabled", {31'd0, oe_seen}, 32'h0);
      read_check("t6_status_after", 4'h4, 32'h2);

      // en cleared after the frame has started: byte still received, next frame ignored.
      bus_write(4'h0, 32'h1);
      oe_seen = 1'b0;
      spi_ss = 1'b0;
      clks(8);
      bus_write(4'h0, 32'h0);
      mo_b[0] = 8'h5A;
      send_bytes(1);
      clks(6);
      spi_ss = 1'b1;
      clks(6);
      check("t7_oe_seen", {31'd0, oe_seen}, 32'h1);
      read_check("t7_rxdata", 4'hC, 32'h5A);
      read_check("t7_status", 4'h4, 32'h3);
      mo_b[0] = 8'hC3;
      frame(1);
      check("t7_no_reentry", {31'd0, oe_seen}, 32'h0);
      read_check("t7_rxdata_kept", 4'hC, 32'h5A);

      // Randomized frames against the model.
      do_reset();
      bus_write(4'h0, 32'h3);
      m_tx_buf = 8'h00; m_tx_empty = 1'b1;
      m_rx_buf = 8'h00; m_rx_valid = 1'b0; m_rx_ovr = 1'b0;
      for (int it = 0; it < 20; it++) begin
         int n;
         logic [31:0] w;
         if ($urandom_range(0, 1) == 1) begin
            w = $urandom;
            bus_write(4'h8, w);
            m_tx_buf = w[7:0];
            m_tx_empty = 1'b0;
         end
         n = $urandom_range(1, 3);
         for (int b = 0; b < 4; b++) mo_b[b] = 8'($urandom);
         exp_mi[0] = m_tx_empty ? 8'hFF : m_tx_buf;
         for (int b = 1; b < 4; b++) exp_mi[b] = 8'hFF;
         m_tx_empty = 1'b1;
         if (m_rx_valid || n > 1) m_rx_ovr = 1'b1;
         m_rx_valid = 1'b1;
         m_rx_buf = mo_b[n-1];
         frame(n);
         for (int b = 0; b < n; b++)
            check($sformatf("rnd%0d_miso%0d", it, b), {24'd0, mi_b[b]}, {24'd0, exp_mi[b]});
         read_check($sformatf("rnd%0d_rxdata", it), 4'hC, {24'd0, m_rx_buf});
         read_check($sformatf("rnd%0d_status", it), 4'h4,
                    {28'd0, 1'b0, m_rx_ovr, m_tx_empty, m_rx_valid});
         check($sformatf("rnd%0d_int", it), {31'd0, int_sig_o}, {31'd0, m_rx_valid});
         w = $urandom;
         bus_write(4'h4, w);
         if (w[0]) m_rx_valid = 1'b0;
         if (w[2]) m_rx_ovr = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
